// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with busy scoreboard; REG_FILE_SB_BYPASS_EN enables write-to-read forwarding
module reg_file_sb #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   input  logic              RSV,
   input  logic [ADDR_W-1:0] RSVADDRESS,
   output logic              BUSY1,
   output logic              BUSY2,
   output logic              ERR
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy, busy_next;
   logic              wr_en, rsv_en, err_next, zero1, zero2;
   // Hardwired-zero register swallows writes and reserves so it never flags ERR
   assign wr_en    = WRITE && !(ZERO_REG != 0 && INADDRESS == '0);
   assign rsv_en   = RSV && !(ZERO_REG != 0 && RSVADDRESS == '0);
   assign err_next = (rsv_en && busy[RSVADDRESS]) || (wr_en && !busy[INADDRESS]);
   assign zero1    = ZERO_REG != 0 && OUT1ADDRESS == '0;
   assign zero2    = ZERO_REG != 0 && OUT2ADDRESS == '0;
   // Reserve is applied after the writeback clear so a same-address reserve wins
   always_comb begin
      busy_next = busy;
      if (wr_en) busy_next[INADDRESS] = 1'b0;
      if (rsv_en) busy_next[RSVADDRESS] = 1'b1;
   end
`ifdef REG_FILE_SB_BYPASS_EN
   logic fwd1, fwd2;
   assign fwd1  = wr_en && OUT1ADDRESS == INADDRESS;
   assign fwd2  = wr_en && OUT2ADDRESS == INADDRESS;
   assign OUT1  = zero1 ? '0 : fwd1 ? IN : regs[OUT1ADDRESS];
   assign OUT2  = zero2 ? '0 : fwd2 ? IN : regs[OUT2ADDRESS];
   assign BUSY1 = !zero1 && !fwd1 && busy[OUT1ADDRESS];
   assign BUSY2 = !zero2 && !fwd2 && busy[OUT2ADDRESS];
`else
   assign OUT1  = zero1 ? '0 : regs[OUT1ADDRESS];
   assign OUT2  = zero2 ? '0 : regs[OUT2ADDRESS];
   assign BUSY1 = !zero1 && busy[OUT1ADDRESS];
   assign BUSY2 = !zero2 && busy[OUT2ADDRESS];
`endif
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
         ERR  <= 1'b0;
      end else begin
         if (wr_en) regs[INADDRESS] <= IN;
         busy <= busy_next;
         ERR  <= err_next;
      end
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reg_file_sb (ZERO_REG=0 and ZERO_REG=1 instances on shared stimulus)
module tb_reg_file_sb;
   logic       CLK = 1'b0, RESET = 1'b1, WRITE = 1'b0, RSV = 1'b0;
   logic [7:0] IN = '0;
   logic [2:0] INADDRESS = '0, OUT1ADDRESS = '0, OUT2ADDRESS = '0, RSVADDRESS = '0;
   logic [7:0] out1, out2, z_out1, z_out2;
   logic       busy1, busy2, err, z_busy1, z_busy2, z_err;
   int         n_chk = 0, n_fail = 0;
`ifdef REG_FILE_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   always #5 CLK = ~CLK;
   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1), .OUT2(out2),
      .RSV(RSV), .RSVADDRESS(RSVADDRESS), .BUSY1(busy1), .BUSY2(busy2), .ERR(err));
   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(z_out1), .OUT2(z_out2),
      .RSV(RSV), .RSVADDRESS(RSVADDRESS), .BUSY1(z_busy1), .BUSY2(z_busy2), .ERR(z_err));
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge CLK);
      #1;
   endtask
   initial begin
      tick;
      RESET = 1'b0;
      OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd1;
      #1;
      chk("rst_out1", out1, 8'h00);
      chk("rst_out2", out2, 8'h00);
      chk("rst_busy1", {7'd0, busy1}, 8'd0);
      chk("rst_busy2", {7'd0, busy2}, 8'd0);
      chk("rst_err", {7'd0, err}, 8'd0);
      WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'h11;
      #1;
      chk("pre_wr_r0", out1, BYP ? 8'h11 : 8'h00);
      tick;
      chk("wr_r0", out1, 8'h11);
      chk("wr_r0_err", {7'd0, err}, 8'd1);
      INADDRESS = 3'd1; IN = 8'h88;
      tick;
      chk("wr_r1", out2, 8'h88);
      chk("wr_r1_err", {7'd0, err}, 8'd1);
      WRITE = 1'b0; INADDRESS = 3'd0; IN = 8'hFF;
      tick;
      chk("nowr_r0", out1, 8'h11);
      chk("nowr_err", {7'd0, err}, 8'd0);
      RSV = 1'b1; RSVADDRESS = 3'd3;
      tick;
      RSV = 1'b0; OUT1ADDRESS = 3'd3;
      #1;
      chk("rsv_r3_busy", {7'd0, busy1}, 8'd1);
      chk("rsv_r3_err", {7'd0, err}, 8'd0);
      WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A;
      #1;
      chk("pre_wb_busy", {7'd0, busy1}, BYP ? 8'd0 : 8'd1);
      chk("pre_wb_out", out1, BYP ? 8'h5A : 8'h00);
      tick;
      WRITE = 1'b0;
      chk("wb_r3_busy", {7'd0, busy1}, 8'd0);
      chk("wb_r3_out", out1, 8'h5A);
      chk("wb_r3_err", {7'd0, err}, 8'd0);
      RSV = 1'b1; RSVADDRESS = 3'd3;
      tick;
      chk("rsv1_err", {7'd0, err}, 8'd0);
      tick;
      RSV = 1'b0;
      chk("waw_err", {7'd0, err}, 8'd1);
      chk("waw_busy", {7'd0, busy1}, 8'd1);
      tick;
      chk("waw_err_clr", {7'd0, err}, 8'd0);
      RSV = 1'b1; RSVADDRESS = 3'd4; WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h3C;
      tick;
      RSV = 1'b0; WRITE = 1'b0; OUT1ADDRESS = 3'd4;
      #1;
      chk("same_out", out1, 8'h3C);
      chk("same_busy", {7'd0, busy1}, 8'd1);
      chk("same_err", {7'd0, err}, 8'd1);
      RSV = 1'b1; RSVADDRESS = 3'd6; WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h42;
      tick;
      RSV = 1'b0; WRITE = 1'b0; OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd3;
      #1;
      chk("diff_busy6", {7'd0, busy1}, 8'd1);
      chk("diff_out3", out2, 8'h42);
      chk("diff_busy3", {7'd0, busy2}, 8'd0);
      chk("diff_err", {7'd0, err}, 8'd0);
      OUT2ADDRESS = 3'd2; WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h77;
      #1;
      chk("byp_out2", out2, BYP ? 8'h77 : 8'h00);
      chk("byp_busy2", {7'd0, busy2}, 8'd0);
      tick;
      WRITE = 1'b0;
      chk("wr_r2", out2, 8'h77);
      chk("wr_r2_err", {7'd0, err}, 8'd1);
      RESET = 1'b1;
      tick;
      RESET = 1'b0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd5;
      WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hAA;
      #1;
      chk("z_pre_out1", z_out1, 8'h00);
      tick;
      WRITE = 1'b0;
      chk("z_wr_out1", z_out1, 8'h00);
      chk("z_wr_err", {7'd0, z_err}, 8'd0);
      chk("nz_wr_out1", out1, 8'hAA);
      chk("nz_wr_err", {7'd0, err}, 8'd1);
      RSV = 1'b1; RSVADDRESS = 3'd0;
      tick;
      chk("z_rsv0_busy", {7'd0, z_busy1}, 8'd0);
      chk("z_rsv0_err", {7'd0, z_err}, 8'd0);
      RSVADDRESS = 3'd5; WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h99;
      tick;
      RSV = 1'b0; WRITE = 1'b0;
      chk("z_r5_out", z_out2, 8'h99);
      chk("z_r5_busy", {7'd0, z_busy2}, 8'd1);
      RESET = 1'b1; WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h55; RSV = 1'b1; RSVADDRESS = 3'd1;
      tick;
      RESET = 1'b0; WRITE = 1'b0; RSV = 1'b0; OUT1ADDRESS = 3'd1;
      #1;
      chk("z_rst_out5", z_out2, 8'h00);
      chk("z_rst_busy5", {7'd0, z_busy2}, 8'd0);
      chk("z_rst_err", {7'd0, z_err}, 8'd0);
      chk("rst_out5", out2, 8'h00);
      chk("rst_busy5", {7'd0, busy2}, 8'd0);
      chk("rst_ign_wr", out1, 8'h00);
      chk("rst_ign_rsv", {7'd0, busy1}, 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
